// File: rtl/mult_share_pkg.sv
// Shared helpers for the multiplier-sharing arbiter.
// Width helpers used by the top and its sub-modules.
package mult_share_pkg;

  localparam int MAX_REQ = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: pointer register plus rotated
// priority encoder; pointer moves past each winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_id
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic          w_any;
  logic          w_take;

  // scan from the pointer downwards so the closest requester wins last
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % N);
      if (i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_take  = i_en && w_any;
  assign o_grant = w_take ? (N'(1) << w_win) : '0;
  assign o_id    = w_win;

  // pointer advances to the slot after the winner on every accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_win == IW'(N - 1)) ? '0 : w_win + IW'(1);
    end
  end

endmodule

// File: rtl/mult_share_arbiter_wide_mult.sv
// Fixed-latency multiplier: registered operands, then
// LATENCY product stages; upper OUTPUT_WIDTH bits kept.
module wide_mult #(
  parameter int INPUT1_WIDTH    = 24,
  parameter int INPUT1_UNSIGNED = 1,
  parameter int INPUT2_WIDTH    = 34,
  parameter int INPUT2_UNSIGNED = 1,
  parameter int OUTPUT_WIDTH    = 58,
  parameter int LATENCY         = 6
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [INPUT1_WIDTH-1:0] i_din1,
  input  logic [INPUT2_WIDTH-1:0] i_din2,
  output logic [OUTPUT_WIDTH-1:0] o_dout
);

  localparam int FW = INPUT1_WIDTH + INPUT2_WIDTH;

  logic [INPUT1_WIDTH-1:0]              r_a;
  logic [INPUT2_WIDTH-1:0]              r_b;
  logic                                 w_sa;
  logic                                 w_sb;
  logic signed [FW-1:0]                 w_ax;
  logic signed [FW-1:0]                 w_bx;
  logic signed [FW-1:0]                 w_full;
  logic [LATENCY-1:0][OUTPUT_WIDTH-1:0] r_p;

  assign w_sa   = (INPUT1_UNSIGNED == 0) && r_a[INPUT1_WIDTH-1];
  assign w_sb   = (INPUT2_UNSIGNED == 0) && r_b[INPUT2_WIDTH-1];
  assign w_ax   = FW'($signed({w_sa, r_a}));
  assign w_bx   = FW'($signed({w_sb, r_b}));
  assign w_full = w_ax * w_bx;
  assign o_dout = r_p[LATENCY-1];

  // operand capture followed by the product delay stages
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      r_a <= i_din1;
      r_b <= i_din2;
      r_p <= {r_p[LATENCY-2:0], w_full[FW-1 -: OUTPUT_WIDTH]};
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one wide_mult between NUM_REQ requesters with
// a credit-protected first-word-fall-through result FIFO.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int INPUT1_WIDTH    = 24,
  parameter int INPUT1_UNSIGNED = 1,
  parameter int INPUT2_WIDTH    = 34,
  parameter int INPUT2_UNSIGNED = 1,
  parameter int OUTPUT_WIDTH    = INPUT1_WIDTH + INPUT2_WIDTH,
  parameter int LATENCY         = 6,
  parameter int FIFO_DEPTH      = 8,
  parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*INPUT1_WIDTH-1:0] req_din1,
  input  logic [NUM_REQ*INPUT2_WIDTH-1:0] req_din2,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [OUTPUT_WIDTH-1:0]         res_data,
  output logic [ID_WIDTH-1:0]             res_id,
  output logic [cnt_w(FIFO_DEPTH)-1:0]    in_flight,
  output logic                            busy
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [OUTPUT_WIDTH-1:0] product;
  } res_entry_t;

  if (LATENCY < 2) begin : g_err_lat
    $error("mult_share_arbiter: LATENCY must be >= 2");
  end
  if (FIFO_DEPTH < 1) begin : g_err_depth
    $error("mult_share_arbiter: FIFO_DEPTH must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_err_req
    $error("mult_share_arbiter: NUM_REQ must be 2..16");
  end

  logic                         w_en;
  logic                         w_acc;
  logic [NUM_REQ-1:0]           w_grant;
  logic [ID_WIDTH-1:0]          w_gid;
  logic [INPUT1_WIDTH-1:0]      w_a;
  logic [INPUT2_WIDTH-1:0]      w_b;
  logic [OUTPUT_WIDTH-1:0]      w_dout;
  logic [LATENCY:0]             r_tag_v;
  logic [LATENCY:0][ID_WIDTH-1:0] r_tag_id;
  res_entry_t                   r_mem [FIFO_DEPTH];
  res_entry_t                   w_head;
  logic [PW-1:0]                r_wp;
  logic [PW-1:0]                r_rp;
  logic [CW-1:0]                r_cnt;
  logic [CW-1:0]                r_inflight;
  logic                         w_wr;
  logic                         w_pop;

  // no credit left means no grant; reset also masks grants
  assign w_en = rstn && (r_inflight != CW'(FIFO_DEPTH));

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (req_valid),
    .i_en    (w_en),
    .o_grant (w_grant),
    .o_id    (w_gid)
  );

  assign req_ready = w_grant;
  assign w_acc     = |w_grant;

  // steer the winner's operands into the multiplier
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = req_din1[i*INPUT1_WIDTH +: INPUT1_WIDTH];
        w_b = req_din2[i*INPUT2_WIDTH +: INPUT2_WIDTH];
      end
    end
  end

  wide_mult #(
    .INPUT1_WIDTH    (INPUT1_WIDTH),
    .INPUT1_UNSIGNED (INPUT1_UNSIGNED),
    .INPUT2_WIDTH    (INPUT2_WIDTH),
    .INPUT2_UNSIGNED (INPUT2_UNSIGNED),
    .OUTPUT_WIDTH    (OUTPUT_WIDTH),
    .LATENCY         (LATENCY)
  ) u_mult (
    .clk    (clk),
    .rstn   (rstn),
    .i_din1 (w_a),
    .i_din2 (w_b),
    .o_dout (w_dout)
  );

  // tag line runs one stage past the multiplier so the
  // last tag lines up with the registered product
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[LATENCY-1:0], w_acc};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_gid};
    end
  end

  assign w_wr      = r_tag_v[LATENCY];
  assign res_valid = (r_cnt != '0);
  assign w_pop     = res_valid && res_ready;
  assign w_head    = r_mem[r_rp];
  assign res_data  = w_head.product;
  assign res_id    = w_head.id;
  assign in_flight = r_inflight;
  assign busy      = (r_inflight != '0);

  // result storage needs no reset; occupancy gates the output
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= {r_tag_id[LATENCY], w_dout};
    end
  end

  // FIFO pointers, occupancy and issued-not-popped count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_inflight <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + PW'(1);
      end
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_wr && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_acc && !w_pop) begin
        r_inflight <= r_inflight + CW'(1);
      end else if (!w_acc && w_pop) begin
        r_inflight <= r_inflight - CW'(1);
      end
    end
  end

endmodule
